alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
- EX-stage datapath of the 5-stage MIPS pipeline.
- Consumes the 4-bit ALUctl code from the ALU control decoder, the operands and the destination register from ID/EX.
- Computes the ALU result and registers it, with the zero flag and writeback tags, into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- W, 32, datapath width in bits; shift amounts use the low 5 bits.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX slot holds a real instruction.
- ALUctl  in  4  operation code from the ALU control decoder.
- var_shift  in  1  1 = shift amount taken from op_a[4:0]; 0 = taken from shamt.
- op_a  in  W  rs operand, already forwarded.
- op_b  in  W  rt operand or immediate, already forwarded.
- shamt  in  5  instruction shamt field.
- rd_in  in  REG_AW  destination register.
- reg_write_in  in  1  writeback enable from main control.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  load a bubble into EX/MEM.
- result  out  W  registered ALU result.
- zero  out  1  registered (ALU result == 0).
- rd_out  out  REG_AW  registered destination register.
- reg_write_out  out  1  registered writeback enable.
- out_valid  out  1  EX/MEM slot holds a real instruction.
- ovf  out  1  registered arithmetic overflow (see Optional Feature).

Behaviour:
- Combinational ALU, keyed on ALUctl:
  - 0000 AND; 0001 OR; 0010 ADD (a+b, mod 2^W); 0110 SUB (a−b, mod 2^W); 0011 NOR; 1000 XOR.
  - 0111 SLT: signed compare, result 1 if a<b else 0, zero-extended to W.
  - 0100 SLL: op_b << sa.
  - 0101 SRL: op_b >> sa, logical.
  - 1001 SRLV: op_b >> op_a[4:0], logical, regardless of var_shift.
  - 1010 SRA: op_b >>> sa, arithmetic.
  - sa = op_a[4:0] if var_shift=1, else shamt.
  - Any other code: result 0.
- zero is computed on the combinational result before it is registered.
- EX/MEM register update priority, highest first:
  - reset_n=0 (asynchronous): result=0, zero=0, rd_out=0, reg_write_out=0, out_valid=0, ovf=0.
  - flush=1: bubble. out_valid=0, reg_write_out=0, ovf=0; result, zero and rd_out also cleared to 0. Flush wins over a simultaneous stall.
  - stall=1: all outputs hold their current values.
  - Otherwise load: out_valid=in_valid; reg_write_out=reg_write_in & in_valid; result, zero and rd_out from the current cycle.
- Latency: exactly 1 clock from inputs to registered outputs; throughput 1 per cycle when not stalled.
- in_valid=0 loads a bubble: reg_write_out=0. result and zero are still loaded; they are don't-care.
- reg_write_out must never be 1 while out_valid=0.
- Release of reset_n is synchronous to clk. The first load occurs on the first rising edge with reset_n=1.
- Reset asserted mid-stall clears the register immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ALU_EX_OVF_EN.
- Defined:
  - Signed overflow is detected for ADD (0010) and SUB (0110).
  - On a valid load with overflow: ovf=1 and reg_write_out is forced to 0, so the destination is not written.
  - result still holds the wrapped sum.
  - ovf follows the same stall/flush/reset rules as the other outputs.
- Not defined: the ovf port stays present, tied to 0; no writeback suppression.

Test Plan:
- ADD, op_a=5, op_b=7, rd_in=3, reg_write_in=1, in_valid=1 → next edge: result=12, zero=0, rd_out=3, reg_write_out=1, out_valid=1.
- SUB 0x1234−0x1234 → result=0, zero=1. SLT a=0xFFFFFFFF, b=1 → result=1. SLT a=1, b=0xFFFFFFFF → result=0.
- SRA, op_b=0x80000000, shamt=4, var_shift=0 → result=0xF8000000. SLL with var_shift=1, op_a=0x23, op_b=1 → result=0x8 (shift of 3). SRLV, op_a=31, op_b=0x80000000 → result=1.
- Load ADD 1+1, then stall=1 for 3 cycles while the inputs change → outputs hold result=2. Assert stall and flush in the same cycle → out_valid=0, reg_write_out=0.
- Drive reset_n=0 between clock edges while out_valid=1 → all outputs read 0 before the next edge. After release, a valid AND 0xF0F0 & 0xFF00 → result=0xF000.
- With ALU_EX_OVF_EN defined: ADD 0x7FFFFFFF+1 → result=0x80000000, ovf=1, reg_write_out=0. Without it: same result, ovf=0, reg_write_out=1.

Source files
------------

// File: rtl/alu_ex_stage_if.sv
// rtl/alu_ex_stage_if.sv - ID/EX operand bundle and EX/MEM outputs of the MIPS EX stage
interface alu_ex_stage_if #(
    parameter int W      = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic [3:0]        ALUctl;
    logic              var_shift;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic              stall;
    logic              flush;
    logic [W-1:0]      result;
    logic              zero;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              out_valid;
    logic              ovf;

    modport master (
        output in_valid, ALUctl, var_shift, op_a, op_b, shamt, rd_in, reg_write_in, stall, flush,
        input  result, zero, rd_out, reg_write_out, out_valid, ovf
    );

    modport slave (
        input  in_valid, ALUctl, var_shift, op_a, op_b, shamt, rd_in, reg_write_in, stall, flush,
        output result, zero, rd_out, reg_write_out, out_valid, ovf
    );
endinterface

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - MIPS EX stage: ALU plus EX/MEM register; ALU_EX_OVF_EN enables signed overflow trap
module alu_ex_stage #(
    parameter int W      = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_ex_stage_if.slave ex
);
    logic [4:0]        sa;
    logic [W-1:0]      sum;
    logic [W-1:0]      diff;
    logic [W-1:0]      alu;
    logic              ovf_c;

    logic [W-1:0]      result_d, result_q;
    logic              zero_d, zero_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              reg_write_d, reg_write_q;
    logic              valid_d, valid_q;
    logic              ovf_d, ovf_q;

    assign sa   = ex.var_shift ? ex.op_a[4:0] : ex.shamt;
    assign sum  = ex.op_a + ex.op_b;
    assign diff = ex.op_a - ex.op_b;

    always_comb begin
        alu = '0;
        case (ex.ALUctl)
            4'b0000: alu = ex.op_a & ex.op_b;
            4'b0001: alu = ex.op_a | ex.op_b;
            4'b0010: alu = sum;
            4'b0110: alu = diff;
            4'b0011: alu = ~(ex.op_a | ex.op_b);
            4'b1000: alu = ex.op_a ^ ex.op_b;
            4'b0111: alu = {{(W-1){1'b0}}, ($signed(ex.op_a) < $signed(ex.op_b))};
            4'b0100: alu = ex.op_b << sa;
            4'b0101: alu = ex.op_b >> sa;
            4'b1001: alu = ex.op_b >> ex.op_a[4:0];
            4'b1010: alu = $signed(ex.op_b) >>> sa;
            default: alu = '0;
        endcase
    end

`ifdef ALU_EX_OVF_EN
    // Overflow when operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        ovf_c = 1'b0;
        if (ex.ALUctl == 4'b0010)
            ovf_c = (ex.op_a[W-1] == ex.op_b[W-1]) && (sum[W-1] != ex.op_a[W-1]);
        else if (ex.ALUctl == 4'b0110)
            ovf_c = (ex.op_a[W-1] != ex.op_b[W-1]) && (diff[W-1] != ex.op_a[W-1]);
    end
`else
    assign ovf_c = 1'b0;
`endif

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        if (ex.flush) begin
            result_d    = '0;
            zero_d      = 1'b0;
            rd_d        = '0;
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
            ovf_d       = 1'b0;
        end else if (!ex.stall) begin
            result_d    = alu;
            zero_d      = (alu == '0);
            rd_d        = ex.rd_in;
            valid_d     = ex.in_valid;
            ovf_d       = ex.in_valid & ovf_c;
            reg_write_d = ex.reg_write_in & ex.in_valid & ~ovf_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ex.result        = result_q;
    assign ex.zero          = zero_q;
    assign ex.rd_out        = rd_q;
    assign ex.reg_write_out = reg_write_q;
    assign ex.out_valid     = valid_q;
    assign ex.ovf           = ovf_q;
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - directed-vector bench for alu_ex_stage
module tb_alu_ex_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    alu_ex_stage_if #(.W(32), .REG_AW(5)) bus ();

    alu_ex_stage #(.W(32), .REG_AW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ex      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ctl, input logic vs, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd,
                         input logic rw, input logic v);
        bus.ALUctl       = ctl;
        bus.var_shift    = vs;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.shamt        = sh;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
        bus.in_valid     = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] res, input logic z,
                             input logic [4:0] rd, input logic rw, input logic v, input logic o);
        check({tag, ".result"}, bus.result, res);
        check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
        check({tag, ".rd"}, {27'd0, bus.rd_out}, {27'd0, rd});
        check({tag, ".rw"}, {31'd0, bus.reg_write_out}, {31'd0, rw});
        check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, o});
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(4'b0010, 1'b0, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b1);
        step();
        check_all("reset", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        step();
        check_all("add", 32'd12, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);

        drive(4'b0110, 1'b0, 32'h1234, 32'h1234, 5'd0, 5'd4, 1'b1, 1'b1);
        step();
        check_all("sub", 32'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);

        drive(4'b0111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        step();
        check("slt_neg", bus.result, 32'd1);

        drive(4'b0111, 1'b0, 32'd1, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b1, 1'b1);
        step();
        check("slt_pos", bus.result, 32'd0);
        check("slt_pos.zero", {31'd0, bus.zero}, 32'd1);

        drive(4'b1010, 1'b0, 32'h0000_0011, 32'h8000_0000, 5'd4, 5'd6, 1'b1, 1'b1);
        step();
        check("sra", bus.result, 32'hF800_0000);

        drive(4'b0100, 1'b1, 32'h0000_0023, 32'd1, 5'd9, 5'd7, 1'b1, 1'b1);
        step();
        check("sllv", bus.result, 32'h0000_0008);

        drive(4'b1001, 1'b0, 32'd31, 32'h8000_0000, 5'd2, 5'd8, 1'b1, 1'b1);
        step();
        check("srlv", bus.result, 32'd1);

        drive(4'b0101, 1'b0, 32'd0, 32'hF000_0000, 5'd8, 5'd8, 1'b1, 1'b1);
        step();
        check("srl", bus.result, 32'h00F0_0000);

        drive(4'b0011, 1'b0, 32'hFFFF_0000, 32'h0000_00FF, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        check("nor", bus.result, 32'h0000_FF00);

        drive(4'b1000, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        check("xor", bus.result, 32'h5555_5555);

        drive(4'b0001, 1'b0, 32'h0000_0F00, 32'h0000_00F0, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        check("or", bus.result, 32'h0000_0FF0);

        drive(4'b1111, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 5'd10, 1'b1, 1'b1);
        step();
        check_all("badop", 32'd0, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0);

        drive(4'b0010, 1'b0, 32'd1, 32'd2, 5'd0, 5'd11, 1'b1, 1'b0);
        step();
        check("bubble.rw", {31'd0, bus.reg_write_out}, 32'd0);
        check("bubble.valid", {31'd0, bus.out_valid}, 32'd0);

        drive(4'b0010, 1'b0, 32'd1, 32'd1, 5'd0, 5'd12, 1'b1, 1'b1);
        step();
        check_all("add11", 32'd2, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 32'd100 + i, 32'd0, 5'd0, 5'd20 + i[4:0], 1'b0, 1'b1);
            step();
            check_all("stall", 32'd2, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        end
        bus.flush = 1'b1;
        step();
        check_all("flush", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        drive(4'b0010, 1'b0, 32'd40, 32'd2, 5'd0, 5'd13, 1'b1, 1'b1);
        step();
        check("pre_rst.valid", {31'd0, bus.out_valid}, 32'd1);
        bus.stall = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.stall = 1'b0;
        drive(4'b0000, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 5'd14, 1'b1, 1'b1);
        step();
        check_all("and", 32'h0000_F000, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);

        drive(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd15, 1'b1, 1'b1);
        step();
`ifdef ALU_EX_OVF_EN
        check_all("add_ovf", 32'h8000_0000, 1'b0, 5'd15, 1'b0, 1'b1, 1'b1);
`else
        check_all("add_ovf", 32'h8000_0000, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0);
`endif

        drive(4'b0110, 1'b0, 32'h8000_0000, 32'd1, 5'd0, 5'd16, 1'b1, 1'b1);
        step();
`ifdef ALU_EX_OVF_EN
        check_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 5'd16, 1'b0, 1'b1, 1'b1);
`else
        check_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
